// File: rtl/morse_pattern_encoder_pkg.sv
// Shared types and constants for the Morse pattern encoder: FSM states, element
// unit patterns, gap lengths and the character ROM entry layout.
package morse_pattern_encoder_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_EMIT_ELEM = 2'd1,
        S_EMIT_GAP  = 2'd2,
        S_PUBLISH   = 2'd3
    } state_t;

    localparam int LEN_W  = 3;
    localparam int CODE_W = 5;

    // Unit sequences played MSB first: dot = on,off ; dash = on,on,on,off
    localparam logic [1:0] DOT_PAT  = 2'b10;
    localparam logic [3:0] DASH_PAT = 4'b1110;

    localparam int LETTER_GAP = 2;
    localparam int WORD_GAP   = 4;

    typedef struct packed {
        logic              supported;
        logic              is_space;
        logic [LEN_W-1:0]  len;
        logic [CODE_W-1:0] code;
    } rom_entry_t;

    function automatic logic [CODE_W-1:0] reverse_code(input logic [CODE_W-1:0] v);
        logic [CODE_W-1:0] r;
        for (int i = 0; i < CODE_W; i++) r[i] = v[CODE_W-1-i];
        return r;
    endfunction

endpackage

// File: rtl/morse_pattern_encoder_if.sv
// Character-in / pattern-out bundle between a text source and the Morse encoder.
interface morse_pattern_encoder_if #(parameter int WIDTH = 32);
    logic             char_valid;
    logic [7:0]       char_data;
    logic             char_last;
    logic             char_ready;
    logic [WIDTH-1:0] blink_pattern;
    logic             pattern_valid;
    logic             pattern_overflow;
    logic             err_char;

    modport master (
        output char_valid, char_data, char_last,
        input  char_ready, blink_pattern, pattern_valid, pattern_overflow, err_char
    );

    modport slave (
        input  char_valid, char_data, char_last,
        output char_ready, blink_pattern, pattern_valid, pattern_overflow, err_char
    );
endinterface

// File: rtl/morse_pattern_encoder_rom.sv
// Combinational ASCII to Morse lookup; code bit i is element i (1 = dash).
module morse_rom
    import morse_pattern_encoder_pkg::*;
(
    input  logic [7:0] i_char,
    output rom_entry_t o_entry
);
    logic [7:0] w_upper;
    logic [7:0] w_ls;
    logic       w_sup;
    logic       w_space;

    assign w_upper = (i_char >= 8'h61 && i_char <= 8'h7A) ? i_char - 8'h20 : i_char;

    // w_ls = {len, elements left-aligned with the first element in bit 4}
    always_comb begin
        w_ls    = 8'd0;
        w_sup   = 1'b1;
        w_space = 1'b0;
        case (w_upper)
            "A": w_ls = {3'd2, 5'b01000};  "B": w_ls = {3'd4, 5'b10000};
            "C": w_ls = {3'd4, 5'b10100};  "D": w_ls = {3'd3, 5'b10000};
            "E": w_ls = {3'd1, 5'b00000};  "F": w_ls = {3'd4, 5'b00100};
            "G": w_ls = {3'd3, 5'b11000};  "H": w_ls = {3'd4, 5'b00000};
            "I": w_ls = {3'd2, 5'b00000};  "J": w_ls = {3'd4, 5'b01110};
            "K": w_ls = {3'd3, 5'b10100};  "L": w_ls = {3'd4, 5'b01000};
            "M": w_ls = {3'd2, 5'b11000};  "N": w_ls = {3'd2, 5'b10000};
            "O": w_ls = {3'd3, 5'b11100};  "P": w_ls = {3'd4, 5'b01100};
            "Q": w_ls = {3'd4, 5'b11010};  "R": w_ls = {3'd3, 5'b01000};
            "S": w_ls = {3'd3, 5'b00000};  "T": w_ls = {3'd1, 5'b10000};
            "U": w_ls = {3'd3, 5'b00100};  "V": w_ls = {3'd4, 5'b00010};
            "W": w_ls = {3'd3, 5'b01100};  "X": w_ls = {3'd4, 5'b10010};
            "Y": w_ls = {3'd4, 5'b10110};  "Z": w_ls = {3'd4, 5'b11000};
            "0": w_ls = {3'd5, 5'b11111};  "1": w_ls = {3'd5, 5'b01111};
            "2": w_ls = {3'd5, 5'b00111};  "3": w_ls = {3'd5, 5'b00011};
            "4": w_ls = {3'd5, 5'b00001};  "5": w_ls = {3'd5, 5'b00000};
            "6": w_ls = {3'd5, 5'b10000};  "7": w_ls = {3'd5, 5'b11000};
            "8": w_ls = {3'd5, 5'b11100};  "9": w_ls = {3'd5, 5'b11110};
            " ": w_space = 1'b1;
            default: w_sup = 1'b0;
        endcase
    end

    assign o_entry.supported = w_sup;
    assign o_entry.is_space  = w_space;
    assign o_entry.len       = w_ls[7:5];
    assign o_entry.code      = reverse_code(w_ls[4:0]);
endmodule

// File: rtl/morse_pattern_encoder.sv
// Streams ASCII text into a Morse on/off pattern word, one unit per clock, and
// publishes the packed word on the message's last character.
module morse_pattern_encoder
    import morse_pattern_encoder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    morse_pattern_encoder_if.slave  bus
);
    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);
    localparam logic [WIDTH-1:0]  MSB_ONE  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t            r_state, w_next;
    rom_entry_t        w_rom;
    logic [LEN_W-1:0]  r_len, r_elem;
    logic [CODE_W-1:0] r_code;
    logic              r_space, r_last;
    logic [1:0]        r_unit, w_gap_last;
    logic [FILL_W-1:0] r_fill;
    logic [WIDTH-1:0]  r_build, r_blink;
    logic              r_ovf_pend, r_ovf, r_pv, r_err;
    logic              w_accept, w_is_dash, w_unit_en, w_unit_bit, w_elem_end;

    morse_rom u_rom (.i_char(bus.char_data), .o_entry(w_rom));

    assign bus.char_ready       = (r_state == S_IDLE);
    assign bus.blink_pattern    = r_blink;
    assign bus.pattern_valid    = r_pv;
    assign bus.pattern_overflow = r_ovf;
    assign bus.err_char         = r_err;

    assign w_accept   = bus.char_valid && bus.char_ready;
    assign w_is_dash  = r_code[r_elem];
    assign w_gap_last = r_space ? 2'(WORD_GAP - 1) : 2'(LETTER_GAP - 1);

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_unit_en  = 1'b0;
        w_unit_bit = 1'b0;
        w_elem_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_rom.supported)   w_next = bus.char_last ? S_PUBLISH : S_IDLE;
                    else if (w_rom.is_space) w_next = S_EMIT_GAP;
                    else                     w_next = S_EMIT_ELEM;
                end
            end
            S_EMIT_ELEM: begin
                w_unit_en  = 1'b1;
                w_unit_bit = w_is_dash ? DASH_PAT[2'd3 - r_unit] : DOT_PAT[~r_unit[0]];
                w_elem_end = w_is_dash ? (r_unit == 2'd3) : (r_unit == 2'd1);
                if (w_elem_end && r_elem == r_len - 3'd1) w_next = S_EMIT_GAP;
            end
            S_EMIT_GAP: begin
                w_unit_en = 1'b1;
                if (r_unit == w_gap_last) w_next = r_last ? S_PUBLISH : S_IDLE;
            end
            S_PUBLISH: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_code  <= w_rom.code;
            r_len   <= w_rom.len;
            r_space <= w_rom.is_space;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last <= 1'b0;
            r_unit <= 2'd0;
            r_elem <= '0;
        end else if (w_accept) begin
            r_last <= bus.char_last;
            r_unit <= 2'd0;
            r_elem <= '0;
        end else if (r_state == S_EMIT_ELEM) begin
            if (w_elem_end) begin
                r_unit <= 2'd0;
                r_elem <= r_elem + 3'd1;
            end else begin
                r_unit <= r_unit + 2'd1;
            end
        end else if (r_state == S_EMIT_GAP) begin
            r_unit <= r_unit + 2'd1;
        end
    end

    // Units past WIDTH are dropped but still take their cycle, keeping timing fixed
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_build    <= '0;
            r_fill     <= '0;
            r_ovf_pend <= 1'b0;
            r_blink    <= '0;
            r_ovf      <= 1'b0;
            r_pv       <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_pv  <= 1'b0;
            r_err <= w_accept && !w_rom.supported;
            if (r_state == S_PUBLISH) begin
                r_blink    <= r_build;
                r_ovf      <= r_ovf_pend;
                r_pv       <= 1'b1;
                r_build    <= '0;
                r_fill     <= '0;
                r_ovf_pend <= 1'b0;
            end else if (w_unit_en) begin
                if (r_fill < FILL_MAX) begin
                    if (w_unit_bit) r_build <= r_build | (MSB_ONE >> r_fill);
                    r_fill <= r_fill + FILL_W'(1);
                end else begin
                    r_ovf_pend <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_morse_pattern_encoder.sv
// Scoreboard bench for morse_pattern_encoder with a text-level Morse reference model.
module tb_morse_pattern_encoder;
    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] pat;
        logic             ovf;
        int               cyc;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    morse_pattern_encoder_if #(.WIDTH(WIDTH)) bus ();
    morse_pattern_encoder #(.WIDTH(WIDTH)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    exp_t exp_q[$];
    int   err_q[$];
    bit   msg[$];
    int   prev_wait = 0;
    logic [WIDTH-1:0] hold_pat = '0;
    logic             hold_ovf = 1'b0;

    string tbl[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                       ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                       "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                       "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                       "--...", "---..", "----."};

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: strobes and error pulses are popped from the scoreboard queues
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            if (bus.pattern_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("pattern", 64'(bus.blink_pattern), 64'(e.pat));
                    check("overflow", 64'(bus.pattern_overflow), 64'(e.ovf));
                    check("strobe_cycle", 64'(cyc), 64'(e.cyc));
                    hold_pat = e.pat;
                    hold_ovf = e.ovf;
                end
            end else begin
                check("hold_pattern", 64'(bus.blink_pattern), 64'(hold_pat));
                check("hold_overflow", 64'(bus.pattern_overflow), 64'(hold_ovf));
            end
            if (bus.err_char) begin
                if (err_q.size() == 0) check("unexpected_err_char", 64'(1), 64'(0));
                else                   check("err_char_cycle", 64'(cyc), 64'(err_q.pop_front()));
            end
        end
    end

    // Reference model: one accepted character at cycle cyc
    task automatic model_accept(input byte c, input bit last);
        byte   up;
        string s;
        int    n;
        logic [WIDTH-1:0] pat;
        exp_t  e;
        up = (c >= "a" && c <= "z") ? byte'(c - 32) : c;
        n = 0;
        if ((up >= "A" && up <= "Z") || (up >= "0" && up <= "9")) begin
            s = (up >= "A") ? tbl[int'(up) - 65] : tbl[26 + int'(up) - 48];
            for (int i = 0; i < s.len(); i++) begin
                msg.push_back(1'b1);
                if (s[i] == "-") begin msg.push_back(1'b1); msg.push_back(1'b1); n += 2; end
                msg.push_back(1'b0);
                n += 2;
            end
            msg.push_back(1'b0); msg.push_back(1'b0);
            n += 2;
        end else if (up == " ") begin
            for (int i = 0; i < 4; i++) msg.push_back(1'b0);
            n = 4;
        end else begin
            err_q.push_back(cyc);
        end
        prev_wait = n + (last ? 1 : 0);
        if (last) begin
            pat = '0;
            for (int k = 0; k < WIDTH && k < msg.size(); k++) pat[WIDTH-1-k] = msg[k];
            e.pat = pat;
            e.ovf = (msg.size() > WIDTH);
            e.cyc = cyc + n + 1;
            exp_q.push_back(e);
            msg.delete();
        end
    endtask

    task automatic send(input byte c, input bit last);
        int waited;
        waited = 0;
        bus.char_valid = 1'b1;
        bus.char_data  = 8'($urandom);
        bus.char_last  = 1'($urandom);
        @(negedge CLK);
        while (!bus.char_ready) begin
            waited++;
            bus.char_data = 8'($urandom);
            bus.char_last = 1'($urandom);
            if (waited > 200) begin
                $display("FAIL ready_timeout: char_ready still 0 after %0d cycles, expected 1", waited);
                $fatal(1, "char_ready timeout");
            end
            @(negedge CLK);
        end
        bus.char_data = c;
        bus.char_last = last;
        @(posedge CLK);
        #1;
        bus.char_valid = 1'b0;
        check("ready_wait", 64'(waited), 64'(prev_wait));
        model_accept(c, last);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], i == s.len() - 1);
    endtask

    initial begin
        string unsup;
        int    len, r, guard;
        byte   c;
        unsup = "#!?@[`.,";
        bus.char_valid = 1'b0;
        bus.char_data  = 8'd0;
        bus.char_last  = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("reset_ready", 64'(bus.char_ready), 64'(1));
        check("reset_pattern", 64'(bus.blink_pattern), 64'(0));
        check("reset_valid", 64'(bus.pattern_valid), 64'(0));
        check("reset_overflow", 64'(bus.pattern_overflow), 64'(0));
        check("reset_err", 64'(bus.err_char), 64'(0));
        @(posedge CLK); #1;

        send_str("SOS");
        send_str("e");
        send_str("E E");
        send_str("00");
        send_str("T");
        send_str("#");
        send_str("a#Z");

        send("O", 1'b0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        hold_pat = '0;
        hold_ovf = 1'b0;
        msg.delete();
        prev_wait = 0;
        @(negedge CLK);
        check("midreset_ready", 64'(bus.char_ready), 64'(1));
        check("midreset_pattern", 64'(bus.blink_pattern), 64'(0));
        check("midreset_valid", 64'(bus.pattern_valid), 64'(0));
        @(posedge CLK); #1;
        send_str("T");

        for (int m = 0; m < 25; m++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                if (r < 4)      c = byte'(65 + $urandom_range(0, 25));
                else if (r < 6) c = byte'(97 + $urandom_range(0, 25));
                else if (r < 8) c = byte'(48 + $urandom_range(0, 9));
                else if (r < 9) c = " ";
                else            c = unsup[$urandom_range(0, unsup.len() - 1)];
                send(c, i == len - 1);
            end
        end

        guard = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0) && guard < 200) begin
            @(posedge CLK);
            guard++;
        end
        #1;
        check("pending_strobes", 64'(exp_q.size()), 64'(0));
        check("pending_err_pulses", 64'(err_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
